// File: rtl/unidad_mul_div_secuencial_pkg.sv
// Shared definitions for the sequential multiply/divide unit and the 8x16 register bank.
// Operation encodings, FSM states and default widths.
package unidad_mul_div_secuencial_pkg;

    localparam int ANCHO_DEF     = 16;
    localparam int DIR_ANCHO_DEF = 3;

    typedef enum logic [1:0] {
        OP_MUL_BAJO = 2'b00,
        OP_MUL_ALTO = 2'b01,
        OP_DIV_COC  = 2'b10,
        OP_DIV_RES  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        REPOSO   = 2'b00,
        CALCULO  = 2'b01,
        ESCRIBIR = 2'b10
    } estado_e;

endpackage

// File: rtl/unidad_mul_div_secuencial_if.sv
// Request/write-back bundle between the register bank, its issuer and the mul/div unit.
// slave is the unit side, master is the issuing side.
interface unidad_mul_div_secuencial_if
    import unidad_mul_div_secuencial_pkg::*;
#(
    parameter int ANCHO     = ANCHO_DEF,
    parameter int DIR_ANCHO = DIR_ANCHO_DEF
);
    logic                 Iniciar;
    logic [1:0]           Operacion;
    logic [ANCHO-1:0]     OperandoA;
    logic [ANCHO-1:0]     OperandoB;
    logic [DIR_ANCHO-1:0] DireccionDestino;
    logic                 Ocupado;
    logic [ANCHO-1:0]     Resultado;
    logic                 HabilitarEscritura;
    logic [DIR_ANCHO-1:0] DireccionEscritura;
    logic                 DivisionCero;

    modport master (
        output Iniciar, Operacion, OperandoA, OperandoB, DireccionDestino,
        input  Ocupado, Resultado, HabilitarEscritura, DireccionEscritura, DivisionCero
    );

    modport slave (
        input  Iniciar, Operacion, OperandoA, OperandoB, DireccionDestino,
        output Ocupado, Resultado, HabilitarEscritura, DireccionEscritura, DivisionCero
    );
endinterface

// File: rtl/unidad_mul_div_secuencial_paso.sv
// paso_mul_div: one combinational iteration (shift-add multiply or restoring divide step).
// The divide path exists only when UNIDAD_DIVISION_EN is defined.
module paso_mul_div
    import unidad_mul_div_secuencial_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
`ifdef UNIDAD_DIVISION_EN
    input  logic               es_div,
`endif
    input  logic [ANCHO-1:0]   operando,
    input  logic [2*ANCHO-1:0] acc_actual,
    output logic [2*ANCHO-1:0] acc_siguiente
);
    logic [ANCHO:0]     suma;
    logic [2*ANCHO:0]   mul_ext;
    logic [2*ANCHO-1:0] mul_sig;

    // Carry out of the upper-half add lands in the MSB after the right shift.
    always_comb begin
        suma    = {1'b0, acc_actual[2*ANCHO-1:ANCHO]} + {1'b0, operando};
        mul_ext = acc_actual[0] ? {suma, acc_actual[ANCHO-1:0]} : {1'b0, acc_actual};
        mul_sig = mul_ext[2*ANCHO:1];
    end

`ifdef UNIDAD_DIVISION_EN
    logic [2*ANCHO:0]   desp;
    logic [ANCHO+1:0]   resta;
    logic [2*ANCHO-1:0] div_sig;

    // Two guard bits keep the borrow unambiguous even with a zero divisor.
    always_comb begin
        desp  = {acc_actual, 1'b0};
        resta = {1'b0, desp[2*ANCHO:ANCHO]} - {2'b00, operando};
        if (!resta[ANCHO+1]) begin
            div_sig = {resta[ANCHO-1:0], desp[ANCHO-1:1], 1'b1};
        end else begin
            div_sig = desp[2*ANCHO-1:0];
        end
        acc_siguiente = es_div ? div_sig : mul_sig;
    end
`else
    assign acc_siguiente = mul_sig;
`endif

endmodule

// File: rtl/unidad_mul_div_secuencial.sv
// Multi-cycle unsigned MUL/DIVU execute unit feeding the register bank write port.
// Divider enabled by UNIDAD_DIVISION_EN; otherwise DIVU ops write 0 with identical timing.
module unidad_mul_div_secuencial
    import unidad_mul_div_secuencial_pkg::*;
#(
    parameter int ANCHO     = ANCHO_DEF,
    parameter int DIR_ANCHO = DIR_ANCHO_DEF
) (
    input  logic                          Reloj,
    input  logic                          Reiniciar,
    unidad_mul_div_secuencial_if.slave    bus
);
    localparam int CNT_W = $clog2(ANCHO);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ANCHO - 1);

    estado_e              estado_q, estado_d;
    logic [CNT_W-1:0]     contador_q, contador_d;
    logic [2*ANCHO-1:0]   acc_q, acc_d, acc_sig;
    logic [ANCHO-1:0]     operando_q, operando_d;
    op_e                  op_q, op_d;
    logic [DIR_ANCHO-1:0] dir_q, dir_d;
    logic [ANCHO-1:0]     resultado_q, resultado_d;
    logic                 div_cero_q, div_cero_d;

    paso_mul_div #(.ANCHO(ANCHO)) u_paso (
`ifdef UNIDAD_DIVISION_EN
        .es_div        (op_q[1]),
`endif
        .operando      (operando_q),
        .acc_actual    (acc_q),
        .acc_siguiente (acc_sig)
    );

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        estado_d    = estado_q;
        contador_d  = contador_q;
        acc_d       = acc_q;
        operando_d  = operando_q;
        op_d        = op_q;
        dir_d       = dir_q;
        resultado_d = resultado_q;
        div_cero_d  = div_cero_q;

        case (estado_q)
            REPOSO: begin
                if (bus.Iniciar) begin
                    op_d       = op_e'(bus.Operacion);
                    dir_d      = bus.DireccionDestino;
                    div_cero_d = 1'b0;
                    contador_d = CNT_MAX;
                    estado_d   = CALCULO;
                    // Divide keeps the divisor and seeds the quotient half with the dividend.
                    if (bus.Operacion[1]) begin
                        operando_d = bus.OperandoB;
                        acc_d      = {{ANCHO{1'b0}}, bus.OperandoA};
                    end else begin
                        operando_d = bus.OperandoA;
                        acc_d      = {{ANCHO{1'b0}}, bus.OperandoB};
                    end
                end
            end
            CALCULO: begin
                acc_d = acc_sig;
                if (contador_q == '0) begin
                    estado_d = ESCRIBIR;
                    case (op_q)
                        OP_MUL_BAJO: resultado_d = acc_sig[ANCHO-1:0];
                        OP_MUL_ALTO: resultado_d = acc_sig[2*ANCHO-1:ANCHO];
`ifdef UNIDAD_DIVISION_EN
                        OP_DIV_COC:  resultado_d = acc_sig[ANCHO-1:0];
                        OP_DIV_RES:  resultado_d = acc_sig[2*ANCHO-1:ANCHO];
`endif
                        default:     resultado_d = '0;
                    endcase
`ifdef UNIDAD_DIVISION_EN
                    div_cero_d = op_q[1] && (operando_q == '0);
`endif
                end else begin
                    contador_d = contador_q - 1'b1;
                end
            end
            ESCRIBIR: estado_d = REPOSO;
            default:  estado_d = REPOSO;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Reloj or posedge Reiniciar) begin
        if (Reiniciar) begin
            estado_q    <= REPOSO;
            contador_q  <= '0;
            acc_q       <= '0;
            operando_q  <= '0;
            op_q        <= OP_MUL_BAJO;
            dir_q       <= '0;
            resultado_q <= '0;
            div_cero_q  <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            contador_q  <= contador_d;
            acc_q       <= acc_d;
            operando_q  <= operando_d;
            op_q        <= op_d;
            dir_q       <= dir_d;
            resultado_q <= resultado_d;
            div_cero_q  <= div_cero_d;
        end
    end

    assign bus.Ocupado            = (estado_q != REPOSO);
    assign bus.HabilitarEscritura = (estado_q == ESCRIBIR);
    assign bus.Resultado          = resultado_q;
    assign bus.DireccionEscritura = dir_q;
    assign bus.DivisionCero       = div_cero_q;

endmodule
